// File: rtl/mem_access_bridge.sv
// MEM-stage load/store unit: big-endian lane steering, sign/zero extension and
// LWL/LWR merge, with a req/ready RAM handshake, timeout and pipeline stall.
module mem_access_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_address,
  input  logic [31:0] op_store_data,
  input  logic [31:0] op_reg_old,
  input  logic        flush,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        address_error,
  output logic        bus_error,
  output logic        ram_enable,
  output logic        ram_write,
  output logic [31:0] ram_address,
  output logic [3:0]  ram_select,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] ONES = '1;

  localparam logic [3:0] OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11, OP_SWR = 4'd12;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [1:0]     off_q;
  logic [31:0]    old_q;
  logic           is_load_q;
  logic           flush_seen_q;
  logic [CW-1:0]  cnt_q;

  logic           is_load, is_store, misaligned;
  logic [3:0]     st_sel;
  logic [31:0]    st_data;
  logic [31:0]    rd_merged;
  logic           issue, access_ok, access_to;

  logic [1:0]     k;
  assign k = op_address[1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    st_sel     = 4'b1111;
    st_data    = '0;
    case (op_code)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; misaligned = k[0];        end
      OP_LW:         begin is_load = 1'b1; misaligned = (k != 2'b00); end
      OP_SB: begin
        is_store = 1'b1;
        st_data  = {4{op_store_data[7:0]}};
        st_sel   = 4'b1000 >> k;
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = k[0];
        st_data    = {2{op_store_data[15:0]}};
        st_sel     = k[1] ? 4'b0011 : 4'b1100;
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (k != 2'b00);
        st_data    = op_store_data;
      end
      OP_SWL: begin
        is_store = 1'b1;
        st_data  = op_store_data >> {k, 3'b000};
        st_sel   = 4'b1111 >> k;
      end
      OP_SWR: begin
        // 3-k equals ~k on two bits
        is_store = 1'b1;
        st_data  = op_store_data << {~k, 3'b000};
        st_sel   = 4'b1111 << ~k;
      end
      default: ;
    endcase
  end

  // Read-side extraction works on the op captured at issue time.
  logic [31:0] rd_byte_sh, rd_half_sh;
  assign rd_byte_sh = ram_read_data >> {~off_q, 3'b000};
  assign rd_half_sh = ram_read_data >> {~off_q[1], 4'b0000};

  always_comb begin
    rd_merged = ram_read_data;
    case (op_q)
      OP_LB:  rd_merged = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      OP_LBU: rd_merged = {24'h0, rd_byte_sh[7:0]};
      OP_LH:  rd_merged = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      OP_LHU: rd_merged = {16'h0, rd_half_sh[15:0]};
      OP_LWL: rd_merged = (ram_read_data << {off_q, 3'b000})
                        | (old_q & ~(ONES << {off_q, 3'b000}));
      OP_LWR: rd_merged = (ram_read_data >> {~off_q, 3'b000})
                        | (old_q & ~(ONES >> {~off_q, 3'b000}));
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    issue     = 1'b0;
    access_ok = 1'b0;
    access_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && (is_load || is_store) && !misaligned) begin
          issue   = 1'b1;
          stall   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (ram_ready) begin
          access_ok = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          access_to = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stall must fall with reset even while an aligned op is still presented.
    if (!reset) stall = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_valid     <= 1'b0;
      load_data      <= '0;
      address_error  <= 1'b0;
      bus_error      <= 1'b0;
      ram_enable     <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_select     <= '0;
      ram_write_data <= '0;
      op_q           <= '0;
      off_q          <= '0;
      old_q          <= '0;
      is_load_q      <= 1'b0;
      flush_seen_q   <= 1'b0;
      cnt_q          <= '0;
    end else begin
      address_error <= (state_q == IDLE) && op_valid && (is_load || is_store) && misaligned;
      bus_error     <= access_to;
      load_valid    <= access_ok && is_load_q && !(flush_seen_q || flush);
      if (access_ok && is_load_q && !(flush_seen_q || flush))
        load_data <= rd_merged;

      if (issue) begin
        ram_enable     <= 1'b1;
        ram_write      <= is_store;
        ram_address    <= {op_address[31:2], 2'b00};
        ram_select     <= st_sel;
        ram_write_data <= st_data;
        op_q           <= op_code;
        off_q          <= k;
        old_q          <= op_reg_old;
        is_load_q      <= is_load;
        flush_seen_q   <= flush;
        cnt_q          <= '0;
      end else if (state_q == ACCESS) begin
        flush_seen_q <= flush_seen_q || flush;
        if (access_ok || access_to) begin
          ram_enable     <= 1'b0;
          ram_write      <= 1'b0;
          ram_address    <= '0;
          ram_select     <= '0;
          ram_write_data <= '0;
          cnt_q          <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
